alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters: none.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_opcode  in  5  ALU opcode, 0x00-0x16 valid.
REQ-008 cmd_a, cmd_b  in  8 each  operand values.
REQ-009 cmd_count  in  3  repeat count for shift opcodes; 0 means 1.
REQ-010 cmd_flags  in  1  update ALU flag latch with the final result.
REQ-011 alu_opcode  out  5  opcode driven to ALU.
REQ-012 alu_reg_a, alu_reg_b  out  8 each  operand registers driven to ALU.
REQ-013 alu_out_n  out  1  ALU result enable, active low.
REQ-014 alu_f_out_n  out  1  flag-read enable, active low; held at 1.
REQ-015 alu_f_load  out  1  flag latch enable.
REQ-016 alu_data  in  8  ALU result bus.
REQ-017 res_valid  out  1  result available.
REQ-018 res_ready  in  1  consumer accepts result.
REQ-019 res_data  out  8  captured result.
REQ-020 res_err  out  1  command carried an invalid opcode.

Function
REQ-021 States: IDLE, EXEC, DONE.
REQ-022 IDLE: cmd_ready=1; on cmd_valid, latch opcode/operands/flags into registers and go to EXEC.
REQ-023 Remaining count: cmd_count, with 0 treated as 1. It is forced to 1 for opcodes outside 0x0F-0x16.
REQ-024 EXEC, each cycle: alu_out_n=0 and alu_opcode = latched opcode.
REQ-025 EXEC, each edge: capture alu_data into res_data.
REQ-026 EXEC, remaining>1: write alu_data into both alu_reg_a and alu_reg_b, decrement remaining, stay in EXEC.
REQ-027 EXEC, remaining=1: go to DONE.
REQ-028 alu_f_load is high only during the final EXEC cycle, and only when latched flags=1. It pulses exactly once per command.
REQ-029 Latency: res_valid rises N+1 edges after the accepting edge, where N is the effective count.
REQ-030 Invalid opcode (0x17-0x1F): go IDLE->DONE directly, with no EXEC cycle. alu_out_n stays 1, alu_f_load stays 0, res_data=0x00, res_err=1.
REQ-031 DONE: res_valid=1; res_data and res_err are held stable until res_ready=1, then go to IDLE. cmd_ready=0 in DONE, so there is no same-cycle accept.
REQ-032 Outside EXEC: alu_out_n=1 and alu_f_load=0.
REQ-033 cmd_valid is ignored outside IDLE.
REQ-034 All arithmetic is 8-bit; the decrement never underflows.

Reset
REQ-035 rst=1 at an edge forces IDLE from any state, including mid-iteration.
REQ-036 Reset values: cmd_ready=1, res_valid=0, res_err=0, res_data=0x00, alu_reg_a=alu_reg_b=0x00, alu_opcode=0x00, alu_out_n=1, alu_f_out_n=1, alu_f_load=0.

Configuration
REQ-037 Macro ALU_SEQ_REPEAT_EN is defined: multi-cycle shift repetition per REQ-023/REQ-026.
REQ-038 Macro ALU_SEQ_REPEAT_EN is undefined: cmd_count is ignored, the effective count is always 1, and the remaining-count register is omitted.

Verification
REQ-039 Add: opcode 0x07, a=0x05, b=0x03, flags=1 -> exactly 1 EXEC cycle, alu_f_load pulses once, res_data=0x08, res_err=0.
REQ-040 Repeated shift: opcode 0x15, a=0x01, count=3 -> with macro, 3 EXEC cycles and res_data=0x08; without macro, 1 cycle and res_data=0x02.
REQ-041 Count on a non-shift opcode: opcode 0x08, a=0x03, b=0x05, count=5 -> 1 EXEC cycle, res_data=0xFE.
REQ-042 Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data stable, cmd_ready=0, and a cmd_valid pulse is ignored.
REQ-043 Invalid opcode: 0x1F -> res_valid on the second edge, res_err=1, res_data=0x00, alu_out_n never low.
REQ-044 Reset mid-operation: rst during the 2nd EXEC cycle of count=4 -> next cycle cmd_ready=1, res_valid=0, alu_out_n=1, alu_f_load never pulsed.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bundles the command, ALU and result buses of the ALU sequencer.
// slave is the sequencer's view; master is the environment's view,
// which drives commands, consumes results and models the ALU.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_count;
  logic       cmd_flags;

  logic [4:0] alu_opcode;
  logic [7:0] alu_reg_a;
  logic [7:0] alu_reg_b;
  logic       alu_out_n;
  logic       alu_f_out_n;
  logic       alu_f_load;
  logic [7:0] alu_data;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_count, cmd_flags,
    output cmd_ready,
    output alu_opcode, alu_reg_a, alu_reg_b, alu_out_n, alu_f_out_n, alu_f_load,
    input  alu_data,
    output res_valid, res_data, res_err,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_count, cmd_flags,
    input  cmd_ready,
    input  alu_opcode, alu_reg_a, alu_reg_b, alu_out_n, alu_f_out_n, alu_f_load,
    output alu_data,
    input  res_valid, res_data, res_err,
    output res_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one command, drives the external ALU for one or
// more cycles, captures the result and holds it until the consumer takes it.
// Optional feature macro ALU_SEQ_REPEAT_EN: when defined, shift opcodes
// (0x0F-0x16) are repeated cmd_count times by feeding the ALU result back
// into both operand registers; when undefined every command runs once.
module alu_sequencer (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] opcode_q;
  logic [7:0] reg_a_q;
  logic [7:0] reg_b_q;
  logic       flags_q;
  logic [7:0] res_data_q;
  logic       res_err_q;
  logic       res_valid_q;
  logic       last_exec;
  logic       cmd_invalid;
  logic       res_taken;

  assign cmd_invalid = (bus.cmd_opcode > 5'h16);
  // A result leaves DONE only once it has actually been presented.
  assign res_taken   = res_valid_q && bus.res_ready;

`ifdef ALU_SEQ_REPEAT_EN
  logic [2:0] rem_q;
  logic       is_shift;

  assign is_shift  = (bus.cmd_opcode >= 5'h0F) && (bus.cmd_opcode <= 5'h16);
  assign last_exec = (rem_q <= 3'd1);

  // Remaining-iteration counter; a count of 0 runs once, non-shifts run once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= 3'd1;
    end else if (state_q == IDLE && bus.cmd_valid) begin
      rem_q <= (is_shift && bus.cmd_count != 3'd0) ? bus.cmd_count : 3'd1;
    end else if (state_q == EXEC && !last_exec) begin
      rem_q <= rem_q - 3'd1;
    end
  end
`else
  assign last_exec = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; invalid opcodes bypass EXEC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) state_d = cmd_invalid ? DONE : EXEC;
      EXEC: if (last_exec) state_d = DONE;
      DONE: if (res_taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, operand feedback and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q   <= 5'h00;
      reg_a_q    <= 8'h00;
      reg_b_q    <= 8'h00;
      flags_q    <= 1'b0;
      res_data_q <= 8'h00;
      res_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            opcode_q  <= bus.cmd_opcode;
            reg_a_q   <= bus.cmd_a;
            reg_b_q   <= bus.cmd_b;
            flags_q   <= bus.cmd_flags;
            res_err_q <= cmd_invalid;
            if (cmd_invalid) res_data_q <= 8'h00;
          end
        end
        EXEC: begin
          res_data_q <= bus.alu_data;
          if (!last_exec) begin
            reg_a_q <= bus.alu_data;
            reg_b_q <= bus.alu_data;
          end
        end
        default: ;
      endcase
    end
  end

  // res_valid rises one edge after entering DONE and drops on hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= (state_q == DONE) && !res_taken;
    end
  end

  // Bus outputs decoded from the current state.
  always_comb begin
    bus.cmd_ready   = (state_q == IDLE);
    bus.alu_out_n   = (state_q != EXEC);
    bus.alu_f_load  = (state_q == EXEC) && last_exec && flags_q;
    bus.alu_f_out_n = 1'b1;
    bus.alu_opcode  = opcode_q;
    bus.alu_reg_a   = reg_a_q;
    bus.alu_reg_b   = reg_b_q;
    bus.res_valid   = res_valid_q;
    bus.res_data    = res_data_q;
    bus.res_err     = res_err_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small ALU model.
// Expected values for shift repetition follow ALU_SEQ_REPEAT_EN.
module tb_alu_sequencer;

  logic clk;
  logic rst;
  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef ALU_SEQ_REPEAT_EN
  localparam int         SHIFT_N    = 3;
  localparam logic [7:0] SHIFT_DATA = 8'h08;
  localparam int         MID_LOADS  = 0;
`else
  localparam int         SHIFT_N    = 1;
  localparam logic [7:0] SHIFT_DATA = 8'h02;
  localparam int         MID_LOADS  = 1;
`endif

  int total  = 0;
  int passed = 0;
  int exec_cnt  = 0;
  int fload_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: add, subtract, shift-left, xor otherwise; bus idles at 0xAA.
  always_comb begin
    if (bus.alu_out_n) bus.alu_data = 8'hAA;
    else begin
      case (bus.alu_opcode)
        5'h07:   bus.alu_data = bus.alu_reg_a + bus.alu_reg_b;
        5'h08:   bus.alu_data = bus.alu_reg_a - bus.alu_reg_b;
        5'h15:   bus.alu_data = {bus.alu_reg_a[6:0], 1'b0};
        default: bus.alu_data = bus.alu_reg_a ^ bus.alu_reg_b;
      endcase
    end
  end

  // Counts EXEC cycles and flag-load pulses seen at each edge.
  always @(posedge clk) begin
    if (!bus.alu_out_n) exec_cnt <= exec_cnt + 1;
    if (bus.alu_f_load) fload_cnt <= fload_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offers one command, then waits (bounded) for res_valid without acking.
  task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] cnt, input logic fl,
                       output int lat, output int execs, output int loads);
    int e0, l0;
    @(negedge clk);
    bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b;
    bus.cmd_count = cnt; bus.cmd_flags = fl; bus.cmd_valid = 1'b1;
    e0 = exec_cnt; l0 = fload_cnt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    execs = exec_cnt - e0;
    loads = fload_cnt - l0;
    $display("cmd op=%02h a=%02h b=%02h cnt=%0d fl=%0b -> lat=%0d execs=%0d loads=%0d data=%02h err=%0b",
             op, a, b, cnt, fl, lat, execs, loads, bus.res_data, bus.res_err);
  endtask

  task automatic ack();
    @(negedge clk); bus.res_ready = 1'b1;
    @(posedge clk); #1; bus.res_ready = 1'b0;
  endtask

  initial begin
    int lat, execs, loads, e0, l0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = 5'h00; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
    bus.cmd_count = 3'd0; bus.cmd_flags = 1'b0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Reset state.
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_err",   bus.res_err, 0);
    check("rst_res_data",  bus.res_data, 8'h00);
    check("rst_reg_a",     bus.alu_reg_a, 8'h00);
    check("rst_reg_b",     bus.alu_reg_b, 8'h00);
    check("rst_opcode",    bus.alu_opcode, 5'h00);
    check("rst_out_n",     bus.alu_out_n, 1);
    check("rst_f_out_n",   bus.alu_f_out_n, 1);
    check("rst_f_load",    bus.alu_f_load, 0);

    // Add with flag update.
    issue(5'h07, 8'h05, 8'h03, 3'd0, 1'b1, lat, execs, loads);
    check("add_lat",   lat, 2);
    check("add_execs", execs, 1);
    check("add_loads", loads, 1);
    check("add_data",  bus.res_data, 8'h08);
    check("add_err",   bus.res_err, 0);
    ack();
    check("add_ready_after_ack", bus.cmd_ready, 1);
    check("add_valid_after_ack", bus.res_valid, 0);

    // Repeated shift.
    issue(5'h15, 8'h01, 8'h00, 3'd3, 1'b1, lat, execs, loads);
    check("shl_lat",   lat, SHIFT_N + 1);
    check("shl_execs", execs, SHIFT_N);
    check("shl_loads", loads, 1);
    check("shl_data",  bus.res_data, SHIFT_DATA);
    ack();

    // Count ignored on a non-shift opcode, then backpressure on its result.
    issue(5'h08, 8'h03, 8'h05, 3'd5, 1'b0, lat, execs, loads);
    check("sub_lat",   lat, 2);
    check("sub_execs", execs, 1);
    check("sub_loads", loads, 0);
    check("sub_data",  bus.res_data, 8'hFE);
    e0 = exec_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data",  bus.res_data, 8'hFE);
      check("bp_ready", bus.cmd_ready, 0);
      check("bp_valid", bus.res_valid, 1);
      bus.cmd_opcode = 5'h07;
      bus.cmd_valid  = (i == 2);
    end
    @(negedge clk); bus.cmd_valid = 1'b0;
    check("bp_no_exec", exec_cnt - e0, 0);
    check("bp_data_end", bus.res_data, 8'hFE);
    ack();
    check("bp_ready_after_ack", bus.cmd_ready, 1);
    check("bp_valid_after_ack", bus.res_valid, 0);

    // Invalid opcode.
    issue(5'h1F, 8'h12, 8'h34, 3'd2, 1'b1, lat, execs, loads);
    check("inv_lat",   lat, 1);
    check("inv_execs", execs, 0);
    check("inv_loads", loads, 0);
    check("inv_err",   bus.res_err, 1);
    check("inv_data",  bus.res_data, 8'h00);
    ack();

    // Reset during the second EXEC cycle of a count=4 shift.
    @(negedge clk);
    bus.cmd_opcode = 5'h15; bus.cmd_a = 8'h01; bus.cmd_b = 8'h00;
    bus.cmd_count = 3'd4; bus.cmd_flags = 1'b1; bus.cmd_valid = 1'b1;
    l0 = fload_cnt;
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    $display("mid-reset: cmd_ready=%0b res_valid=%0b out_n=%0b loads=%0d",
             bus.cmd_ready, bus.res_valid, bus.alu_out_n, fload_cnt - l0);
    check("mid_cmd_ready", bus.cmd_ready, 1);
    check("mid_res_valid", bus.res_valid, 0);
    check("mid_out_n",     bus.alu_out_n, 1);
    check("mid_loads",     fload_cnt - l0, MID_LOADS);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
